// File: rtl/sp24_pkg.sv
// rtl/sp24_pkg.sv - shared constants, half-selection type and magnitude helper for the 2:4 encoder
package sp24_pkg;

  localparam int LANES = 4;
  localparam int HALF  = 4;
  localparam int IDX_W = 2;
  localparam int W_W   = 8;

  // Result of compressing one 4-weight half down to two kept weights.
  // idx0 < idx1 always; w0/w1 are the weights found at those positions.
  typedef struct packed {
    logic [IDX_W-1:0] idx0;
    logic [IDX_W-1:0] idx1;
    logic [W_W-1:0]   w0;
    logic [W_W-1:0]   w1;
    logic             lossy;
  } half_sel_t;

  // Unsigned magnitude of an int8; -128 maps to 8'h80 (128) without overflow.
  function automatic logic [W_W-1:0] abs8(input logic [W_W-1:0] w);
    return w[W_W-1] ? (~w + 1'b1) : w;
  endfunction

endpackage

// File: rtl/sp24_half_select.sv
// rtl/sp24_half_select.sv - picks the two weights kept from one 4-weight half
module sp24_half_select
  import sp24_pkg::*;
(
  input  logic [HALF*W_W-1:0] half_w,
  output half_sel_t           sel
);

  logic [W_W-1:0]  w   [HALF];
  logic [W_W-1:0]  mag [HALF];
  logic [HALF-1:0] keep;
  logic [2:0]      nz;
  logic [2:0]      beaten;
  logic            first;

  // Unpack the half into weights and their magnitudes.
  always_comb begin
    for (int i = 0; i < HALF; i++) begin
      w[i]   = half_w[i*W_W +: W_W];
      mag[i] = abs8(w[i]);
    end
  end

  // A position is kept when fewer than two others outrank it. Rank is by
  // magnitude with the lower position winning ties; because zeros have the
  // smallest magnitude this single ordering also keeps every nonzero when there
  // are at most two and pads with the lowest zero positions.
  always_comb begin
    keep   = '0;
    nz     = '0;
    beaten = '0;
    for (int i = 0; i < HALF; i++) begin
      beaten = '0;
      if (w[i] != '0) nz = nz + 3'd1;
      for (int j = 0; j < HALF; j++) begin
        if (j != i) begin
          if ((mag[j] > mag[i]) || ((mag[j] == mag[i]) && (j < i))) begin
            beaten = beaten + 3'd1;
          end
        end
      end
      keep[i] = (beaten < 3'd2);
    end
  end

  // Exactly two positions are kept; scanning upward yields ascending indices.
  always_comb begin
    sel   = '0;
    first = 1'b1;
    for (int i = 0; i < HALF; i++) begin
      if (keep[i]) begin
        if (first) begin
          sel.idx0 = IDX_W'(i);
          sel.w0   = w[i];
          first    = 1'b0;
        end else begin
          sel.idx1 = IDX_W'(i);
          sel.w1   = w[i];
        end
      end
    end
    sel.lossy = (nz > 3'd2);
  end

endmodule

// File: rtl/sp24_weight_encoder.sv
// rtl/sp24_weight_encoder.sv - two-stage streaming 2:4 sparsity compressor with lossy-half counter
module sp24_weight_encoder
  import sp24_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [2*HALF*W_W-1:0]   in_dense,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANES*W_W-1:0]    out_weight,
  output logic [LANES*IDX_W-1:0]  out_idx,
  output logic                    out_lossy,
  output logic [CNT_W-1:0]        lossy_cnt,
  input  logic                    cnt_clr
);

  half_sel_t        sel_a;
  half_sel_t        sel_b;
  half_sel_t        s1_a;
  half_sel_t        s1_b;
  logic             s1_valid;
  logic [1:0]       s2_nlossy;
  logic             s2_adv;
  logic             s1_adv;
  logic             out_fire;
  logic [CNT_W:0]   cnt_sum;

  sp24_half_select u_half_a (
    .half_w (in_dense[HALF*W_W-1:0]),
    .sel    (sel_a)
  );

  sp24_half_select u_half_b (
    .half_w (in_dense[2*HALF*W_W-1:HALF*W_W]),
    .sel    (sel_b)
  );

  // A stage may load when the stage after it is empty or draining this cycle.
  assign s2_adv   = ~out_valid | out_ready;
  assign s1_adv   = ~s1_valid | s2_adv;
  assign in_ready = s1_adv;
  assign out_fire = out_valid & out_ready;
  assign cnt_sum  = {1'b0, lossy_cnt} + (CNT_W+1)'(s2_nlossy);

  // Stage 1: capture the per-half selections of the accepted dense beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_a <= sel_a;
        s1_b <= sel_b;
      end
    end
  end

  // Stage 2: pack lanes into the output format; held while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_weight <= '0;
      out_idx    <= '0;
      out_lossy  <= 1'b0;
      s2_nlossy  <= '0;
    end else if (s2_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_weight <= {s1_b.w1, s1_b.w0, s1_a.w1, s1_a.w0};
        out_idx    <= {s1_b.idx1, s1_b.idx0, s1_a.idx1, s1_a.idx0};
        out_lossy  <= s1_a.lossy | s1_b.lossy;
        s2_nlossy  <= {1'b0, s1_a.lossy} + {1'b0, s1_b.lossy};
      end
    end
  end

  // Saturating count of pruned halves, bumped at the output handshake; clear wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      lossy_cnt <= '0;
    end else if (cnt_clr) begin
      lossy_cnt <= '0;
    end else if (out_fire) begin
      lossy_cnt <= cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
    end
  end

endmodule
